// File: rtl/signature_byte_reader.sv
// Reads the serial signature ROM MSB-first and delivers it as bytes over a valid/ready handshake.
// The ROM position is re-synchronised through a registered restart pulse at every new readout.
module signature_byte_reader #(
  parameter int NUM_BYTES = 32,
  parameter int IDX_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sig_q,
  output logic             sig_en,
  output logic             sig_restart,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [IDX_W-1:0] byte_index,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESTART = 3'd1,
    SHIFT   = 3'd2,
    HOLD    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t     state, state_n;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       last_byte;
  logic       accept;

  assign last_byte = (byte_index == LAST_IDX);
  assign accept    = (state == HOLD) && byte_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RESTART;
      RESTART: state_n = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_n = HOLD;
      HOLD:    if (byte_ready) state_n = last_byte ? DONE : SHIFT;
      DONE:    if (start) state_n = RESTART;
      default: state_n = IDLE;
    endcase
  end

  // ROM enable is asserted only while shifting, so a stalled consumer never costs a ROM bit.
  assign sig_en     = (state == SHIFT);
  assign byte_valid = (state == HOLD);
  assign busy       = (state == RESTART) || (state == SHIFT) || (state == HOLD);
  assign done       = (state == DONE);

  // sig_restart comes straight from a flop because it drives the ROM's asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sig_restart <= 1'b0;
    end else begin
      state       <= state_n;
      sig_restart <= (state_n == RESTART);
    end
  end

  // sig_q is sampled on the same edge the ROM advances; no extra alignment stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      byte_data  <= 8'd0;
      byte_index <= '0;
    end else begin
      unique case (state)
        RESTART: begin
          bit_cnt    <= 3'd0;
          shreg      <= 7'd0;
          byte_index <= '0;
        end
        SHIFT: begin
          shreg   <= {shreg[5:0], sig_q};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_data <= {shreg, sig_q};
        end
        HOLD: begin
          if (accept && !last_byte) byte_index <= byte_index + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
